// File: rtl/cam_gray_window_stream.sv
// Camera byte-stream capture with a cropped, decimated 8-bit grey output and marker bytes.
// The RGB565 byte pairs are summed into a 7-bit luma proxy (R5+G6+B5). Groups of D pixels
// are then averaged horizontally, and the lines between output rows are skipped. Results and
// the frame/line markers go through a first-word-fall-through FIFO to a valid/ready sink.
module cam_gray_window_stream #(
    parameter int unsigned LINE_SIZE    = 640,
    parameter int unsigned WIN_X0       = 0,
    parameter int unsigned WIN_Y0       = 0,
    parameter int unsigned WIN_W        = 80,
    parameter int unsigned WIN_H        = 60,
    parameter int unsigned DEC_LOG2     = 0,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [7:0]  FRAME_MARK   = 8'h2B,
    parameter logic [7:0]  LINE_MARK    = 8'h2D,
    parameter bit          LINE_MARK_EN = 1'b0
) (
    input  logic       PCLK,
    input  logic       RST,
    input  logic       HREF,
    input  logic       VSYNC,
    input  logic [7:0] PDATA,
    output logic [7:0] ODATA,
    output logic       OVALID,
    input  logic       OREADY,
    output logic       OVERFLOW
);

    localparam int unsigned D      = 1 << DEC_LOG2;
    localparam int          DM     = int'(D) - 1;
    localparam int unsigned XW     = $clog2(LINE_SIZE + 1);
    localparam int unsigned YW     = 16;
    localparam int unsigned AW     = 7 + DEC_LOG2;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam int          WIN_XS = int'(WIN_W * D);
    localparam int          WIN_YS = int'(WIN_H * D);

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    logic          vs_q, vs_qq;
    logic          href_q;
    logic          phase_q;      // 0: expecting high byte, 1: expecting low byte
    logic [7:0]    hi_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] acc_q;

    logic          frame_start;
    logic          href_eff;
    logic          href_fall;
    logic          lo_byte;
    logic [6:0]    sum7;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] avg;
    logic [7:0]    grey;
    int            x_rel;
    int            y_rel;
    logic          x_ok;
    logic          x_in;
    logic          y_in;
    logic          last_in_group;
    logic          pix_in;

    // Push request into the FIFO
    logic          push;
    logic [7:0]    push_data;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          full;
    logic          pop;
    logic          do_write;
    logic          drop;

    // Decode frame/line events, window membership and the grey value of the current pixel
    always_comb begin
        frame_start   = vs_q & ~vs_qq;
        // HREF is masked while the registered VSYNC is high
        href_eff      = HREF & ~vs_q;
        href_fall     = ~href_eff & href_q;
        lo_byte       = href_eff & phase_q;

        sum7          = 7'(hi_q[7:3]) + 7'({hi_q[2:0], PDATA[7:5]}) + 7'(PDATA[4:0]);
        acc_sum       = acc_q + AW'(sum7);
        avg           = acc_sum >> DEC_LOG2;
        grey          = 8'({avg, 1'b0});

        x_rel         = int'(x_q) - int'(WIN_X0);
        y_rel         = int'(y_q) - int'(WIN_Y0);
        x_ok          = int'(x_q) < int'(LINE_SIZE);
        x_in          = (x_rel >= 0) && (x_rel < WIN_XS);
        // Only every D-th window line is an output line
        y_in          = (y_rel >= 0) && (y_rel < WIN_YS) && ((y_rel & DM) == 0);
        last_in_group = (x_rel & DM) == DM;
        pix_in        = lo_byte & x_ok & x_in & y_in;
    end

    // Select the single active push source for this cycle
    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        if (frame_start) begin
            push      = 1'b1;
            push_data = FRAME_MARK;
        end else if (pix_in && last_in_group) begin
            push      = 1'b1;
            push_data = grey;
        end else if (href_fall && LINE_MARK_EN && y_in) begin
            // y_q still holds the line that just finished
            push      = 1'b1;
            push_data = LINE_MARK;
        end
    end

    // Sync registers, byte phase, pixel/line counters and the decimation accumulator
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
        end else begin
            vs_q   <= VSYNC;
            vs_qq  <= vs_q;
            href_q <= href_eff;
            if (frame_start) begin
                x_q     <= '0;
                y_q     <= '0;
                phase_q <= 1'b0;
                acc_q   <= '0;
            end else if (href_fall) begin
                // An unpaired high byte is dropped simply by resetting the phase
                x_q     <= '0;
                phase_q <= 1'b0;
                acc_q   <= '0;
                if (y_q != '1) begin
                    y_q <= y_q + YW'(1);
                end
            end else if (href_eff) begin
                if (!phase_q) begin
                    hi_q    <= PDATA;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (x_ok) begin
                        x_q <= x_q + XW'(1);
                    end
                    if (pix_in) begin
                        acc_q <= last_in_group ? '0 : acc_sum;
                    end
                end
            end
        end
    end

    // FIFO handshake decode; a pop frees the slot a same-cycle push lands in
    always_comb begin
        OVALID   = cnt_q != '0;
        full     = cnt_q == CW'(FIFO_DEPTH);
        pop      = OVALID & OREADY;
        do_write = push & (~full | pop);
        drop     = push & full & ~pop;
        ODATA    = mem_q[rptr_q];
    end

    // FIFO storage
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (do_write) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_write) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            unique case ({do_write, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky overflow flag; a dropped frame marker re-arms it in the same cycle it clears
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
        end else if (frame_start) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_gray_window_stream.sv
// Directed bench for cam_gray_window_stream: window at (2,1), 2x2 output, D=2, 4-deep FIFO,
// line markers enabled. Expected bytes are queued as stimulus is driven and are checked as
// the sink accepts them.
module tb_cam_gray_window_stream;

    localparam int X0 = 2;
    localparam int Y0 = 1;
    localparam int WW = 2;
    localparam int WH = 2;
    localparam int DF = 2;

    logic       PCLK = 1'b0;
    logic       RST;
    logic       HREF;
    logic       VSYNC;
    logic [7:0] PDATA;
    logic [7:0] ODATA;
    logic       OVALID;
    logic       OREADY;
    logic       OVERFLOW;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;
    bit         gate = 1'b0;

    cam_gray_window_stream #(
        .LINE_SIZE   (16),
        .WIN_X0      (X0),
        .WIN_Y0      (Y0),
        .WIN_W       (WW),
        .WIN_H       (WH),
        .DEC_LOG2    (1),
        .FIFO_DEPTH  (4),
        .FRAME_MARK  (8'h2B),
        .LINE_MARK   (8'h2D),
        .LINE_MARK_EN(1'b1)
    ) dut (
        .PCLK    (PCLK),
        .RST     (RST),
        .HREF    (HREF),
        .VSYNC   (VSYNC),
        .PDATA   (PDATA),
        .ODATA   (ODATA),
        .OVALID  (OVALID),
        .OREADY  (OREADY),
        .OVERFLOW(OVERFLOW)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Grey level of one RGB565 pixel, from its colour fields
    function automatic int s_of(input logic [15:0] p);
        int r;
        int g;
        int b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return r + g + b;
    endfunction

    function automatic logic [7:0] gexp(input logic [15:0] a, input logic [15:0] b);
        return 8'(((s_of(a) + s_of(b)) / 2) * 2);
    endfunction

    function automatic logic [15:0] pixel(input int y, input int i);
        if (y == 1) begin
            case (i)
                2, 3, 4: return 16'hFFFF;
                5:       return 16'h0841;
                default: ;
            endcase
        end
        return 16'(y * 4999 + i * 1237 + 313);
    endfunction

    function automatic bit out_line(input int y);
        return (y >= Y0) && (y < Y0 + WH * DF) && (((y - Y0) % DF) == 0);
    endfunction

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic pix(input logic [15:0] p, input bit rlo);
        step();
        HREF  = 1'b1;
        PDATA = p[15:8];
        if (gate) OREADY = 1'b0;
        step();
        PDATA = p[7:0];
        if (gate) OREADY = rlo;
    endtask

    // One 8-pixel camera line; keep = how many of its outputs the FIFO is expected to hold
    task automatic line(input int y, input bit odd, input int keep);
        logic [7:0] e [3];
        if (out_line(y)) begin
            e[0] = gexp(pixel(y, 2), pixel(y, 3));
            e[1] = gexp(pixel(y, 4), pixel(y, 5));
            e[2] = 8'h2D;
            for (int k = 0; k < keep; k++) exp_q.push_back(e[k]);
        end
        for (int i = 0; i < 8; i++) pix(pixel(y, i), (i == 3) || (i == 5));
        if (odd) begin
            step();
            PDATA = 8'hA5;
            if (gate) OREADY = 1'b0;
        end
        step();
        HREF  = 1'b0;
        PDATA = 8'h00;
        if (gate) OREADY = out_line(y);
        step();
        if (gate) OREADY = 1'b0;
        step();
    endtask

    task automatic vsync_pulse();
        exp_q.push_back(8'h2B);
        step();
        VSYNC = 1'b1;
        repeat (3) step();
        VSYNC = 1'b0;
        repeat (3) step();
    endtask

    task automatic frame();
        vsync_pulse();
        for (int y = 0; y < 6; y++) line(y, y == 1, 3);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        repeat (3) step();
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: compare every accepted byte against the oldest expected byte
    always @(negedge PCLK) begin
        if (!RST && OVALID && OREADY) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_byte: observed %0h expected none", ODATA);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert (ODATA === mon_e) else begin
                    errors++;
                    $error("FAIL odata: observed %0h expected %0h", ODATA, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        RST    = 1'b0;
        HREF   = 1'b0;
        VSYNC  = 1'b0;
        PDATA  = 8'h00;
        OREADY = 1'b0;
        #1 RST = 1'b1;
        repeat (3) step();
        chk("rst_ovalid", OVALID, 0);
        chk("rst_odata", ODATA, 8'h00);
        chk("rst_overflow", OVERFLOW, 0);
        RST = 1'b0;
        step();
        chk("post_rst_ovalid", OVALID, 0);

        // Lone VSYNC pulse gives exactly one frame marker
        OREADY = 1'b1;
        vsync_pulse();
        wait_drain("t1_drain");
        chk("t1_ovalid", OVALID, 0);
        chk("t1_overflow", OVERFLOW, 0);

        // Full frame: window crop, averaging, line skipping, markers, odd trailing byte
        frame();
        wait_drain("t2_drain");
        chk("t2_ovalid", OVALID, 0);
        chk("t2_overflow", OVERFLOW, 0);

        // Overflow with a stalled sink, then clear on the next frame start
        OREADY = 1'b0;
        vsync_pulse();
        line(0, 1'b0, 3);
        line(1, 1'b0, 3);
        line(2, 1'b0, 3);
        line(3, 1'b0, 0);
        chk("t3_overflow_set", OVERFLOW, 1);
        chk("t3_ovalid", OVALID, 1);
        chk("t3_head", ODATA, 8'h2B);
        step();
        chk("t3_head_stable", ODATA, 8'h2B);
        OREADY = 1'b1;
        wait_drain("t3_drain");
        chk("t3_overflow_sticky", OVERFLOW, 1);
        vsync_pulse();
        wait_drain("t3_mark_drain");
        chk("t3_overflow_clear", OVERFLOW, 0);

        // Full FIFO with pops only on push cycles: nothing may be dropped
        OREADY = 1'b0;
        vsync_pulse();
        line(0, 1'b0, 3);
        line(1, 1'b0, 3);
        line(2, 1'b0, 3);
        gate = 1'b1;
        line(3, 1'b0, 3);
        gate = 1'b0;
        chk("t5_overflow", OVERFLOW, 0);
        chk("t5_ovalid", OVALID, 1);
        OREADY = 1'b1;
        wait_drain("t5_drain");

        // Reset in the middle of an output line with data pending
        OREADY = 1'b0;
        vsync_pulse();
        line(0, 1'b0, 3);
        for (int i = 0; i < 4; i++) pix(pixel(1, i), 1'b0);
        step();
        RST  = 1'b1;
        HREF = 1'b0;
        #1;
        chk("t6_ovalid", OVALID, 0);
        chk("t6_odata", ODATA, 8'h00);
        chk("t6_overflow", OVERFLOW, 0);
        exp_q.delete();
        repeat (2) step();
        RST = 1'b0;
        step();
        OREADY = 1'b1;
        frame();
        wait_drain("t6_drain");
        chk("t6_final_ovalid", OVALID, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
